char_motion: RTL and testbench

Character motion controller for the scrolling sprite display. It turns keypad direction inputs into the character's world position `char_X`/`char_Y`, with walking, jumping and gravity. Position updates once per frame, on the VGA end-of-frame pulse. Its outputs feed the scroll stage and the sprite overlay stage directly downstream. Every output is registered and changes only in the cycle after a frame tick, so the visible region never sees a mid-frame position change.

---
 rtl/char_motion.sv | 173 +++++++++++++++++
 tb/tb_char_motion.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_motion.sv
// Character motion controller: turns keypad direction inputs into a per-frame
// world position with walking, jumping and gravity. All state advances only on
// frame_tick, so downstream scroll/sprite stages never see a mid-frame change.
module char_motion #(
    parameter logic [9:0] X_START   = 10'd32,
    parameter logic [9:0] X_MAX     = 10'd992,
    parameter logic [9:0] GROUND_Y  = 10'd416,
    parameter logic [9:0] WALK_STEP = 10'd2,
    parameter logic [5:0] JUMP_V    = 6'd12,
    parameter logic [5:0] GRAV      = 6'd1,
    parameter logic [5:0] MAX_FALL  = 6'd8
) (
    input  logic       clk_25mhz,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic [3:0] mov,
    output logic [9:0] char_X,
    output logic [9:0] char_Y,
    output logic       block,
    output logic [1:0] state,
    output logic       facing
);

    localparam int unsigned XW = 11;
    localparam int unsigned VW = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_JUMP = 2'd2,
        S_FALL = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  mov_m;
    logic [3:0]  mov_s;
    logic        up_prev;
    logic [5:0]  vy_q;
    logic [5:0]  vy_d;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic        block_d;
    logic        facing_d;

    logic        up_c;
    logic        down_c;
    logic        left_c;
    logic        right_c;
    logic        hreq_c;
    logic        jump_req_c;
    logic [XW-1:0] x_sum_c;
    logic [XW-1:0] y_sum_c;
    logic [VW-1:0] vy_inc_c;

    assign state      = state_q;
    assign up_c       = mov_s[3];
    assign down_c     = mov_s[2];
    assign left_c     = mov_s[1];
    assign right_c    = mov_s[0];
    assign hreq_c     = left_c ^ right_c;
    assign jump_req_c = up_c & ~up_prev;

    // Two-flop synchronizer for the asynchronous keypad lines
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            mov_m <= '0;
            mov_s <= '0;
        end else begin
            mov_m <= mov;
            mov_s <= mov_m;
        end
    end

    // Motion state register, advanced once per frame
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else if (frame_tick) begin
            state_q <= state_d;
        end
    end

    // Position, velocity and flag registers, committed together on the tick
    always_ff @(posedge clk_25mhz or negedge RST_N) begin
        if (!RST_N) begin
            char_X  <= X_START;
            char_Y  <= GROUND_Y;
            vy_q    <= '0;
            block   <= 1'b0;
            facing  <= 1'b1;
            up_prev <= 1'b0;
        end else if (frame_tick) begin
            char_X  <= x_d;
            char_Y  <= y_d;
            vy_q    <= vy_d;
            block   <= block_d;
            facing  <= facing_d;
            up_prev <= up_c;
        end
    end

    // Horizontal step with 11-bit arithmetic so underflow is seen before the clamp
    always_comb begin
        x_d      = char_X;
        block_d  = 1'b0;
        facing_d = facing;
        x_sum_c  = XW'(char_X);
        if (hreq_c) begin
            facing_d = right_c;
            x_sum_c  = right_c ? XW'(char_X) + XW'(WALK_STEP)
                               : XW'(char_X) - XW'(WALK_STEP);
            if (x_sum_c[XW-1]) begin
                x_d     = '0;
                block_d = 1'b1;
            end else if (x_sum_c > XW'(X_MAX)) begin
                x_d     = X_MAX;
                block_d = 1'b1;
            end else begin
                x_d = x_sum_c[9:0];
            end
        end
    end

    // Next-state and vertical motion; velocity direction is implied by state
    always_comb begin
        state_d  = state_q;
        y_d      = char_Y;
        vy_d     = vy_q;
        y_sum_c  = XW'(char_Y) + XW'(vy_q);
        vy_inc_c = VW'(vy_q) + VW'(GRAV);
        case (state_q)
            S_IDLE, S_WALK: begin
                if (jump_req_c) begin
                    state_d = S_JUMP;
                    vy_d    = JUMP_V;
                end else begin
                    state_d = hreq_c ? S_WALK : S_IDLE;
                end
            end
            S_JUMP: begin
                if (down_c) begin
                    state_d = S_FALL;
                    vy_d    = '0;
                end else if (10'(vy_q) > char_Y) begin
                    state_d = S_FALL;
                    y_d     = '0;
                    vy_d    = '0;
                end else begin
                    y_d = char_Y - 10'(vy_q);
                    if (vy_q <= GRAV) begin
                        state_d = S_FALL;
                        vy_d    = '0;
                    end else begin
                        vy_d = vy_q - GRAV;
                    end
                end
            end
            S_FALL: begin
                if (y_sum_c >= XW'(GROUND_Y)) begin
                    state_d = hreq_c ? S_WALK : S_IDLE;
                    y_d     = GROUND_Y;
                    vy_d    = '0;
                end else begin
                    y_d  = y_sum_c[9:0];
                    vy_d = (vy_inc_c > VW'(MAX_FALL)) ? MAX_FALL : vy_inc_c[5:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_char_motion.sv
// Scoreboard bench for char_motion: the driver pushes the reference model's
// expected outputs per tick, a monitor pops and compares after each tick edge.
module tb_char_motion;

    localparam int X_START  = 32;
    localparam int X_MAX    = 992;
    localparam int GROUND_Y = 416;
    localparam int WALK     = 2;
    localparam int JUMP_V   = 12;
    localparam int GRAV     = 1;
    localparam int MAX_FALL = 8;

    logic       clk_25mhz = 1'b0;
    logic       RST_N = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] mov = 4'd0;
    logic [9:0] char_X;
    logic [9:0] char_Y;
    logic       block;
    logic [1:0] state;
    logic       facing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blk;
        logic [1:0] st;
        logic       face;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_x, m_y, m_vy, m_st;
    bit m_face, m_up;

    char_motion dut (
        .clk_25mhz (clk_25mhz),
        .RST_N     (RST_N),
        .frame_tick(frame_tick),
        .mov       (mov),
        .char_X    (char_X),
        .char_Y    (char_Y),
        .block     (block),
        .state     (state),
        .facing    (facing)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_x = X_START; m_y = GROUND_Y; m_vy = 0; m_st = 0; m_face = 1'b1; m_up = 1'b0;
    endfunction

    // One frame of the game rules, in plain integer arithmetic
    function automatic void model_tick(input logic [3:0] m);
        bit   u, d, l, r, hreq, jreq, blk;
        exp_t e;
        u = m[3]; d = m[2]; l = m[1]; r = m[0];
        hreq = l ^ r;
        jreq = u && !m_up;
        blk  = 1'b0;
        if (hreq) begin
            m_x    = r ? m_x + WALK : m_x - WALK;
            m_face = r;
            if (m_x < 0) begin m_x = 0; blk = 1'b1; end
            else if (m_x > X_MAX) begin m_x = X_MAX; blk = 1'b1; end
        end
        case (m_st)
            0, 1: begin
                if (jreq) begin m_st = 2; m_vy = JUMP_V; end
                else m_st = hreq ? 1 : 0;
            end
            2: begin
                if (d) begin m_st = 3; m_vy = 0; end
                else if (m_vy > m_y) begin m_y = 0; m_vy = 0; m_st = 3; end
                else begin
                    m_y = m_y - m_vy;
                    if (m_vy <= GRAV) begin m_vy = 0; m_st = 3; end
                    else m_vy = m_vy - GRAV;
                end
            end
            default: begin
                if (m_y + m_vy >= GROUND_Y) begin
                    m_y = GROUND_Y; m_vy = 0; m_st = hreq ? 1 : 0;
                end else begin
                    m_y  = m_y + m_vy;
                    m_vy = (m_vy + GRAV > MAX_FALL) ? MAX_FALL : m_vy + GRAV;
                end
            end
        endcase
        m_up   = u;
        e.x    = 10'(m_x);
        e.y    = 10'(m_y);
        e.blk  = blk;
        e.st   = 2'(m_st);
        e.face = m_face;
        sb_q.push_back(e);
    endfunction

    // Present mov, let it cross the synchronizer, then pulse frame_tick for len cycles
    task automatic tick(input logic [3:0] m, input int len);
        @(negedge clk_25mhz);
        mov = m;
        repeat (3) @(negedge clk_25mhz);
        for (int k = 0; k < len; k++) model_tick(m);
        frame_tick = 1'b1;
        repeat (len) @(negedge clk_25mhz);
        frame_tick = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, int'(char_X), X_START);
        chk({tag, "_y"}, int'(char_Y), GROUND_Y);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_block"}, int'(block), 0);
        chk({tag, "_facing"}, int'(facing), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_25mhz);
        RST_N = 1'b0;
        mov   = 4'd0;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk_25mhz);
        frame_tick = 1'b1;
        @(negedge clk_25mhz);
        frame_tick = 1'b0;
        RST_N = 1'b1;
        @(negedge clk_25mhz);
        chk_reset_vals("rst_tick_ignored");
        model_reset();
    endtask

    // Monitor: after every live tick edge, compare outputs with the next expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_25mhz);
            if (frame_tick && RST_N) begin
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got tick with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_x", int'(char_X), int'(e.x));
                    chk("sb_y", int'(char_Y), int'(e.y));
                    chk("sb_block", int'(block), int'(e.blk));
                    chk("sb_state", int'(state), int'(e.st));
                    chk("sb_facing", int'(facing), int'(e.face));
                end
            end
        end
    end

    initial begin
        logic [3:0] m;
        int len;
        model_reset();
        repeat (3) @(negedge clk_25mhz);
        chk_reset_vals("rst_init");
        RST_N = 1'b1;

        // Walk left into the edge
        for (int i = 1; i <= 17; i++) begin
            tick(4'b0010, 1);
            if (i == 16) begin
                chk("walk16_x", int'(char_X), 0);
                chk("walk16_block", int'(block), 0);
            end
        end
        chk("walk17_x", int'(char_X), 0);
        chk("walk17_block", int'(block), 1);
        chk("walk17_state", int'(state), 1);
        chk("walk17_facing", int'(facing), 0);

        // Full jump arc
        tick(4'b1000, 1);
        chk("jump1_state", int'(state), 2);
        chk("jump1_y", int'(char_Y), GROUND_Y);
        for (int i = 1; i <= 27; i++) begin
            tick(4'b0000, 1);
            if (i == 12) begin
                chk("apex_y", int'(char_Y), 338);
                chk("apex_state", int'(state), 3);
            end
        end
        chk("land_y", int'(char_Y), GROUND_Y);
        chk("land_state", int'(state), 0);

        // Jump cut by down
        tick(4'b1000, 1);
        repeat (3) tick(4'b0000, 1);
        tick(4'b0100, 1);
        chk("cut_y", int'(char_Y), 383);
        chk("cut_state", int'(state), 3);
        repeat (12) tick(4'b0000, 1);
        chk("cut_land_y", int'(char_Y), GROUND_Y);
        chk("cut_land_state", int'(state), 0);

        // Reset mid-jump, with a tick during reset
        tick(4'b1000, 1);
        repeat (2) tick(4'b0000, 1);
        do_reset();

        // Held up: only one jump
        for (int i = 0; i < 60; i++) tick(4'b1000, 1);
        chk("held_state", int'(state), 0);
        chk("held_y", int'(char_Y), GROUND_Y);
        tick(4'b0000, 1);

        // Right edge with simultaneous jump
        for (int i = 0; i < 480; i++) tick(4'b0001, 1);
        chk("right_x", int'(char_X), X_MAX);
        chk("right_block0", int'(block), 0);
        tick(4'b1001, 1);
        chk("rclamp_x", int'(char_X), X_MAX);
        chk("rclamp_block", int'(block), 1);
        chk("rclamp_state", int'(state), 2);
        tick(4'b0001, 1);
        chk("rclamp2_x", int'(char_X), X_MAX);
        chk("rclamp2_block", int'(block), 1);

        // Randomized play, including occasional stretched ticks
        for (int i = 0; i < 300; i++) begin
            m = 4'($urandom);
            if ($urandom_range(0, 3) != 0) m[2] = 1'b0;
            len = ($urandom_range(0, 15) == 0) ? 2 : 1;
            tick(m, len);
        end

        repeat (4) @(negedge clk_25mhz);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
